// File: rtl/sad_block_accum.sv
// rtl/sad_block_accum.sv - pipelined block SAD accumulator with minimum-SAD tracker
//
// Accepts one row of INPUTS pixel pairs per valid beat and sums |a-b| over
// ROWS beats into a block SAD. It also tracks the smallest block SAD, and
// the index of the block that produced it, across a candidate search.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b carry a valid row this cycle
//   a, b       current / reference rows, pixel i at [WIDTH*i +: WIDTH]
//   flush      abort the block in progress (synchronous)
//   min_clr    restart the minimum search (synchronous)
//   sad_out    last completed block SAD
//   out_valid  one-cycle strobe when sad_out updates
//   min_sad    smallest block SAD since the last clear
//   min_idx    block index of min_sad
//   blk_idx    blocks completed since the last clear (wraps)
module sad_block_accum #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int ROWS   = 4,
  parameter int IDX_W  = 6,
  localparam int SW    = WIDTH + $clog2(INPUTS) + $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH*INPUTS-1:0] a,
  input  logic [WIDTH*INPUTS-1:0] b,
  input  logic                    flush,
  input  logic                    min_clr,
  output logic [SW-1:0]           sad_out,
  output logic                    out_valid,
  output logic [SW-1:0]           min_sad,
  output logic [IDX_W-1:0]        min_idx,
  output logic [IDX_W-1:0]        blk_idx
);

  localparam int RSW = WIDTH + $clog2(INPUTS);
  // Counter needs at least one bit even when ROWS == 1.
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ROWS - 1);

  // Beat counter
  logic [CW-1:0] cnt_q, cnt_d;
  logic          beat_last;

  // S1
  logic [WIDTH*INPUTS-1:0] a_q, b_q;
  logic                    v1_q, l1_q;
  // S2
  logic [RSW-1:0]          rs_q;
  logic                    v2_q, l2_q;
  // S3
  logic [SW-1:0]           acc_q, acc_d;
  logic [SW-1:0]           sad_q, sad_d;
  logic                    ov_q, ov_d;
  logic [SW-1:0]           min_sad_q, min_sad_d;
  logic [IDX_W-1:0]        min_idx_q, min_idx_d;
  logic [IDX_W-1:0]        blk_idx_q, blk_idx_d;

  logic [RSW-1:0]          row_sum;
  logic signed [WIDTH:0]   diff;
  logic [WIDTH-1:0]        absd;
  logic [SW-1:0]           s_new;
  logic                    complete;
  logic                    take;
  logic [IDX_W-1:0]        base_idx;

  always_comb begin
    beat_last = (cnt_q == LAST_CNT);
    cnt_d     = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (in_valid) begin
      cnt_d = beat_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Row sum of absolute differences, formed from the S1 registers.
  always_comb begin
    row_sum = '0;
    diff    = '0;
    absd    = '0;
    for (int i = 0; i < INPUTS; i++) begin
      diff    = $signed({1'b0, a_q[WIDTH*i +: WIDTH]}) - $signed({1'b0, b_q[WIDTH*i +: WIDTH]});
      absd    = diff[WIDTH] ? WIDTH'(-diff) : diff[WIDTH-1:0];
      row_sum = row_sum + RSW'(absd);
    end
  end

  // S3: accumulate, complete a block, and update the minimum tracker.
  always_comb begin
    s_new    = acc_q + SW'(rs_q);
    complete = v2_q && l2_q && !flush;
    // A clear coinciding with a completion makes that block the first of the new search.
    take     = min_clr || (s_new < min_sad_q);
    base_idx = min_clr ? '0 : blk_idx_q;

    acc_d     = acc_q;
    sad_d     = sad_q;
    ov_d      = complete;
    min_sad_d = min_sad_q;
    min_idx_d = min_idx_q;
    blk_idx_d = blk_idx_q;

    if (flush) begin
      acc_d = '0;
    end else if (v2_q) begin
      acc_d = l2_q ? '0 : s_new;
    end

    if (complete) begin
      sad_d = s_new;
      if (take) begin
        min_sad_d = s_new;
        min_idx_d = base_idx;
      end
      blk_idx_d = base_idx + 1'b1;
    end else if (min_clr) begin
      min_sad_d = '1;
      min_idx_d = '0;
      blk_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      v1_q      <= 1'b0;
      l1_q      <= 1'b0;
      rs_q      <= '0;
      v2_q      <= 1'b0;
      l2_q      <= 1'b0;
      acc_q     <= '0;
      sad_q     <= '0;
      ov_q      <= 1'b0;
      min_sad_q <= '1;
      min_idx_q <= '0;
      blk_idx_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      a_q       <= a;
      b_q       <= b;
      v1_q      <= in_valid && !flush;
      l1_q      <= in_valid && beat_last;
      rs_q      <= row_sum;
      v2_q      <= v1_q && !flush;
      l2_q      <= l1_q;
      acc_q     <= acc_d;
      sad_q     <= sad_d;
      ov_q      <= ov_d;
      min_sad_q <= min_sad_d;
      min_idx_q <= min_idx_d;
      blk_idx_q <= blk_idx_d;
    end
  end

  assign sad_out   = sad_q;
  assign out_valid = ov_q;
  assign min_sad   = min_sad_q;
  assign min_idx   = min_idx_q;
  assign blk_idx   = blk_idx_q;

endmodule
